// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus master and its bus driver.
package mmio_pkg;

  localparam int unsigned BUS_W  = 16;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] IDLE_ADDR_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // readDone floats when nothing is selected; only a clean 1 means done.
  function automatic logic read_done_seen(input logic rd);
    if (rd == 1'b1) return 1'b1;
    else            return 1'b0;
  endfunction

endpackage

// File: rtl/mmio_bus_driver.sv
// Registered address/strobe outputs and tri-state data driver for the shared MMIO bus.
module mmio_bus_driver
  import mmio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [BUS_W-1:0]  wdata_i,
  input  logic              release_i,
  output logic [ADDR_W-1:0] address_o,
  output logic              write_en_o,
  output logic              output_en_o,
  inout  wire  [BUS_W-1:0]  bus_io
);

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              oe_q;
  logic [BUS_W-1:0]  wdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= IDLE_ADDR;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      wdata_q <= '0;
    end else if (start_i) begin
      addr_q  <= addr_i;
      we_q    <= write_i;
      oe_q    <= !write_i;
      wdata_q <= wdata_i;
    end else if (release_i) begin
      addr_q <= IDLE_ADDR;
      we_q   <= 1'b0;
      oe_q   <= 1'b0;
    end
  end

  assign address_o   = addr_q;
  assign write_en_o  = we_q;
  assign output_en_o = oe_q;

  // Reset gates the driver directly so the bus is released without waiting for an edge.
  assign bus_io = (we_q && !rst_i) ? wdata_q : 'z;

endmodule

// File: rtl/mmio_bus_master.sv
// Single-transaction MMIO bus sequencer between the CPU core and memory-mapped peripherals.
// Read timeout/error path is built only when MMIO_BUS_MASTER_TIMEOUT_EN is defined.
module mmio_bus_master
  import mmio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IDLE_ADDR = IDLE_ADDR_DEFAULT,
  parameter int unsigned       TIMEOUT   = 16,
  parameter logic [BUS_W-1:0]  ERR_DATA  = 16'hDEAD
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BUS_W-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [BUS_W-1:0]  rsp_rdata,
  output logic              rsp_error,
  inout  wire  [BUS_W-1:0]  BUS,
  output logic [ADDR_W-1:0] address,
  output logic              writeEn,
  output logic              outputEn,
  input  logic              readDone
);

  state_e           state_q;
  logic             ready_q;
  logic             rsp_valid_q;
  logic [BUS_W-1:0] rdata_q;
  logic             rd_done;
  logic             timeout_hit;
  logic             bus_start;
  logic             bus_release;

  assign rd_done = read_done_seen(readDone);

`ifdef MMIO_BUS_MASTER_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic       err_q;

  // readDone takes priority over an expiring count.
  assign timeout_hit = (state_q == ST_READ) && !rd_done && (cnt_q == CNT_LAST);
  assign rsp_error   = err_q;
`else
  logic unused_params;

  assign unused_params = ^{ERR_DATA, TIMEOUT};
  assign timeout_hit   = 1'b0;
  assign rsp_error     = 1'b0;
`endif

  always_comb begin
    bus_start   = (state_q == ST_IDLE) && ready_q && req_valid;
    bus_release = (state_q == ST_WRITE) ||
                  ((state_q == ST_READ) && (rd_done || timeout_hit));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef MMIO_BUS_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus_start) begin
            state_q <= req_write ? ST_WRITE : ST_READ;
            ready_q <= 1'b0;
`ifdef MMIO_BUS_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_WRITE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
`ifdef MMIO_BUS_MASTER_TIMEOUT_EN
          err_q       <= 1'b0;
`endif
        end
        ST_READ: begin
          if (rd_done) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= BUS;
`ifdef MMIO_BUS_MASTER_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (timeout_hit) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= ERR_DATA;
            err_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  mmio_bus_driver #(
    .IDLE_ADDR (IDLE_ADDR)
  ) u_bus_driver (
    .clk_i       (CLOCK_50),
    .rst_i       (reset),
    .start_i     (bus_start),
    .write_i     (req_write),
    .addr_i      (req_addr),
    .wdata_i     (req_wdata),
    .release_i   (bus_release),
    .address_o   (address),
    .write_en_o  (writeEn),
    .output_en_o (outputEn),
    .bus_io      (BUS)
  );

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_bus_master.sv
// Self-checking bench for mmio_bus_master with a divider/scratch peripheral at base 0.
module tb_mmio_bus_master;

  localparam int TMO = 16;
`ifdef MMIO_BUS_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_error;
  logic [15:0] rsp_rdata;
  wire  [15:0] BUS;
  logic [31:0] address;
  logic        writeEn, outputEn;
  wire         readDone;

  always #5 clk = ~clk;

  mmio_bus_master #(
    .IDLE_ADDR (32'hFFFF_FFFF),
    .TIMEOUT   (TMO),
    .ERR_DATA  (16'hDEAD)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .BUS       (BUS),
    .address   (address),
    .writeEn   (writeEn),
    .outputEn  (outputEn),
    .readDone  (readDone)
  );

  // Peripheral: regs 0..15; reading 2/3 gives quotient/remainder of reg0/reg1.
  logic [15:0] preg [16] = '{default: '0};
  int          periph_lat = 1;
  int          rd_cnt = 0;
  logic [15:0] pdata;
  wire         sel = (address < 32'd16);

  always_comb begin
    pdata = preg[address[3:0]];
    if (address[3:0] == 4'd2) pdata = (preg[1] == 16'd0) ? 16'hFFFF : preg[0] / preg[1];
    if (address[3:0] == 4'd3) pdata = (preg[1] == 16'd0) ? 16'hFFFF : preg[0] % preg[1];
  end

  // Idle bus is held at 0 by a keeper so any stray master drive shows up as a value change.
  assign BUS      = (outputEn && sel) ? pdata : ((!outputEn && !writeEn) ? 16'h0000 : 16'hzzzz);
  assign readDone = (outputEn && sel) ? (rd_cnt >= periph_lat) : 1'bz;

  always @(posedge clk) begin
    if (writeEn && sel) preg[address[3:0]] <= BUS;
    rd_cnt <= (outputEn && sel) ? rd_cnt + 1 : 0;
  end

  int          total = 0;
  int          bad = 0;
  int          rsp_count = 0;
  int          n_exp = 0;
  logic [15:0] cur_wdata = '0;
  logic [15:0] last_rd = '0;
  logic [15:0] mem [16] = '{default: '0};
  bit          prev_rsp = 1'b0;
  bit          prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid === 1'b1) rsp_count++;
      chk("rsp_single_pulse", 32'(rsp_valid && prev_rsp), 32'd0);
      chk("we_single_cycle", 32'(writeEn && prev_we), 32'd0);
      chk("bus_quiet_in_resp_idle", 32'((writeEn || outputEn) && (rsp_valid || req_ready)), 32'd0);
      if (!(writeEn || outputEn)) begin
        chk("idle_address", address, 32'hFFFF_FFFF);
        chk("idle_bus_released", {16'd0, BUS}, 32'd0);
      end
      if (writeEn) chk("write_bus_data", {16'd0, BUS}, {16'd0, cur_wdata});
      prev_rsp = rsp_valid;
      prev_we  = writeEn;
    end
  end

  function automatic logic [15:0] ref_read(input logic [3:0] a);
    if (a == 4'd2) return (mem[1] == 16'd0) ? 16'hFFFF : mem[0] / mem[1];
    if (a == 4'd3) return (mem[1] == 16'd0) ? 16'hFFFF : mem[0] % mem[1];
    return mem[a];
  endfunction

  task automatic do_req(input bit w, input logic [31:0] a, input logic [15:0] d,
                        input int lat, input bit hold, input string tag);
    int          n;
    logic [15:0] exp_d;
    bit          exp_e;
    int          exp_n;
    exp_e = !w && TMO_EN && (lat >= TMO || a >= 32'd16);
    if (w)          begin exp_d = last_rd;       exp_n = 2;       end
    else if (exp_e) begin exp_d = 16'hDEAD;      exp_n = TMO + 1; end
    else            begin exp_d = ref_read(a[3:0]); exp_n = lat + 2; end
    periph_lat = lat;
    cur_wdata  = d;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_d});
    chk({tag, "_error"}, 32'(rsp_error), 32'(exp_e));
    if (w && a < 32'd16) mem[a[3:0]] = d;
    if (!w) last_rd = exp_d;
    n_exp++;
  endtask

  initial begin
    int          n;
    int          rc;
    bit          seen;
    bit          w;
    logic [31:0] a;
    logic [15:0] d;
    int          lat;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_address", address, 32'hFFFF_FFFF);
    chk("rst_writeEn", 32'(writeEn), 32'd0);
    chk("rst_outputEn", 32'(outputEn), 32'd0);
    chk("rst_bus", {16'd0, BUS}, 32'd0);
    reset = 1'b0;

    // Divider: 100 / 7
    do_req(1'b1, 32'd0, 16'd100, 1, 1'b0, "div_wr_a");
    do_req(1'b1, 32'd1, 16'd7,   1, 1'b0, "div_wr_b");
    do_req(1'b0, 32'd2, 16'd0,   1, 1'b0, "div_quot");
    chk("div_quot_14", {16'd0, rsp_rdata}, 32'd14);
    do_req(1'b0, 32'd3, 16'd0,   2, 1'b0, "div_rem");
    chk("div_rem_2", {16'd0, rsp_rdata}, 32'd2);

    do_req(1'b1, 32'd0, 16'h1234, 1, 1'b0, "wr_1234");
    do_req(1'b0, 32'd0, 16'd0,    1, 1'b0, "rd_1234");
    chk("rd_1234_value", {16'd0, rsp_rdata}, 32'h1234);

    // Four reads with req_valid held high throughout.
    do_req(1'b0, 32'd2, 16'd0, 1, 1'b1, "q0");
    do_req(1'b0, 32'd3, 16'd0, 3, 1'b1, "q1");
    do_req(1'b0, 32'd0, 16'd0, 2, 1'b1, "q2");
    do_req(1'b0, 32'd1, 16'd0, 4, 1'b0, "q3");

    // readDone on the same edge the count expires.
    do_req(1'b0, 32'd0, 16'd0, TMO - 1, 1'b0, "tmo_edge");
    do_req(1'b0, 32'd1, 16'd0, TMO, 1'b0, "tmo_late");

`ifdef MMIO_BUS_MASTER_TIMEOUT_EN
    do_req(1'b0, 32'h100, 16'd0, 1, 1'b0, "unmapped");
`else
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("unmapped_no_rsp", 32'(seen), 32'd0);
    chk("unmapped_still_reading", 32'(outputEn), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
    chk("unmapped_rst_rdata", {16'd0, rsp_rdata}, 32'd0);
`endif

    // Reset during the second READ cycle.
    periph_lat = 10; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd0;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    @(negedge clk);
    rc = rsp_count;
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rdabort_outputEn", 32'(outputEn), 32'd0);
    chk("rdabort_address", address, 32'hFFFF_FFFF);
    chk("rdabort_req_ready", 32'(req_ready), 32'd1);
    chk("rdabort_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    last_rd = '0;

    // Reset during the WRITE cycle (unmapped target).
    cur_wdata = 16'hBEEF; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 16'hBEEF;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("wrabort_writeEn", 32'(writeEn), 32'd0);
    chk("wrabort_bus", {16'd0, BUS}, 32'd0);
    chk("wrabort_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", rsp_count, rc);

    for (int i = 0; i < 30; i++) begin
      w   = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 15));
      d   = 16'($urandom);
      lat = $urandom_range(1, TMO + 2);
      if (a == 32'd1 && d == 16'd0) d = 16'd1;
      do_req(w, a, d, lat, 1'($urandom_range(0, 1)), "rand");
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rsp_pulse_count", rsp_count, n_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_bus_master.md
Name: mmio_bus_master

Overview:
- Sequencer that turns single-word read/write requests from the CPU core into transactions on the shared memory-mapped bus (BUS/address/writeEn/outputEn/readDone).
- Sits directly upstream of the memory-mapped peripherals, including the divider, multiplier and IO blocks.
- Holds one transaction in flight, waits for the peripheral's readDone on reads, times out on unmapped addresses, and returns read data to the core.

Parameters:
- IDLE_ADDR, 32'hFFFF_FFFF, address driven while idle; must select no peripheral.
- TIMEOUT, 16, cycles to wait for readDone before flagging an error (range 2..255).
- ERR_DATA, 16'hDEAD, rsp_rdata value returned on a read timeout.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  master can accept a request; transfer occurs when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  word address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  single-cycle pulse: transaction finished.
- rsp_rdata  out  16  read data, valid while rsp_valid is high.
- rsp_error  out  1  read timed out, valid while rsp_valid is high.
- BUS  inout  16  shared data bus; driven only in WRITE, otherwise high-Z.
- address  out  32  bus address.
- writeEn  out  1  bus write strobe.
- outputEn  out  1  bus read enable to the peripherals.
- readDone  in  1  peripheral read-complete; tri-stated when nothing is selected, so only a sampled 1'b1 counts (Z/X/0 mean "not done").

Behaviour:
- FSM states: IDLE, WRITE, READ, RESP.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_error 0, address IDLE_ADDR, writeEn 0, outputEn 0, BUS high-Z, timeout counter 0.
- req_ready = 1 only in IDLE.
- All bus outputs are registered; there is no combinational path from req_* to the bus.
- IDLE:
  - On handshake, latch addr/wdata.
  - Write goes to WRITE; read goes to READ.
  - Set address to req_addr on the same edge; set writeEn=1 (write) or outputEn=1 (read).
- WRITE (exactly 1 cycle): BUS driven with wdata, writeEn=1; the peripheral latches at the end of this cycle.
  - Next edge: writeEn 0, BUS Z, address IDLE_ADDR, go to RESP with rsp_error=0 and rsp_rdata unchanged.
- READ: address held, outputEn=1, writeEn=0; counter increments each cycle.
  - If readDone==1 is sampled: capture BUS into rsp_rdata, rsp_error=0, drop outputEn, address IDLE_ADDR, go to RESP.
  - Minimum read latency is 2 cycles in READ, because peripherals register readDone one cycle after select.
  - If the counter reaches TIMEOUT-1 without readDone: rsp_rdata=ERR_DATA, rsp_error=1, go to RESP.
  - readDone arriving on the same edge as the timeout wins (no error).
- RESP (1 cycle): rsp_valid=1, then return to IDLE with req_ready=1.
  - Request-to-response latency: write 2 cycles; read (2..TIMEOUT) + 1 cycles.
  - Back-to-back requests: minimum 1 idle cycle between bus transactions, which gives registered peripherals (e.g. divider result) a settle cycle.
- Reset mid-transaction: the next edge forces the reset values, BUS releases immediately, and no rsp_valid is issued for the aborted request.
- req_valid while not ready is ignored; the core must hold it.
- The counter is 8-bit; it clears on entry to READ and cannot wrap.

Optional Feature:
- Macro MMIO_BUS_MASTER_TIMEOUT_EN.
- Defined: timeout counter and error path exactly as above.
- Undefined: no counter; READ waits indefinitely for readDone, rsp_error is tied to 0, and the ERR_DATA/TIMEOUT parameters are unused.

Decomposition:
- Shared package (mmio_pkg): FSM state typedef (2-bit enum), IDLE_ADDR default, bus width constant (16), address width constant (32).
- One natural sub-module: mmio_bus_driver, which holds the registered address/writeEn/outputEn plus the tri-state BUS driver, controlled by FSM strobes.
- Timeout counter stays inline.

Test Plan:
- Divider at BASE 0: write 100 to addr 0, write 7 to addr 1, read addr 2 -> rsp_rdata=14, rsp_error=0; read addr 3 -> rsp_rdata=2.
- Write 16'h1234 to addr 0, then read addr 0 -> rsp_rdata=16'h1234; BUS is Z in every cycle except the single WRITE cycle; writeEn is high exactly one cycle.
- Read unmapped addr 32'h100 with TIMEOUT=16 -> rsp_valid after 17 cycles with rsp_error=1 and rsp_rdata=16'hDEAD; with the macro undefined, the master stays in READ and never asserts rsp_valid.
- req_valid held high with 4 queued reads -> each accepted only in IDLE; exactly one rsp_valid pulse per request; at least 1 gap cycle between outputEn windows.
- reset asserted during the second READ cycle -> next edge: outputEn 0, address 32'hFFFF_FFFF, req_ready 1, no rsp_valid.
- readDone forced high on the same edge the timeout expires -> rsp_error=0 and rsp_rdata=BUS value.
